rv_decode_stage: RTL and testbench

- Registered, parametrised RV32/RV64 instruction decode stage that replaces text-only disassembly with machine-usable decode fields.
- Sits between fetch and execute: accepts `{pc, instr}` on a valid/ready handshake and presents one registered decode bundle.
- Supports flush, illegal-instruction detection, and optional M and RV64 W-op support.
- Two wrap-around performance counters.

---
 rtl/rv_decode_stage.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV32/RV64 instruction decode stage: one registered decode bundle behind a
// valid/ready handshake, with illegal-instruction detection and two counters.
module rv_decode_stage #(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output logic [3:0]       op_class,
    output logic             is_word,
    output logic             is_muldiv,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic             writes_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_count,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [3:0] {
        CL_LUI       = 4'd0,
        CL_AUIPC     = 4'd1,
        CL_JAL       = 4'd2,
        CL_JALR      = 4'd3,
        CL_BRANCH    = 4'd4,
        CL_LOAD      = 4'd5,
        CL_STORE     = 4'd6,
        CL_OP_IMM    = 4'd7,
        CL_OP        = 4'd8,
        CL_OP_IMM_32 = 4'd9,
        CL_OP_32     = 4'd10,
        CL_FENCE     = 4'd11,
        CL_SYSTEM    = 4'd12,
        CL_ILLEGAL   = 4'd15
    } op_class_t;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam bit              IS64    = (XLEN == 64);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt, shamt_w;
    logic        f7_ok;

    op_class_t   d_class;
    logic [63:0] d_imm;
    logic        d_word, d_muldiv, d_rs1, d_rs2, d_wr, bad;

    logic        in_xfer, out_xfer;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Immediates are built at 64 bits and truncated, so RV32 needs no special case.
    assign imm_i   = {{52{in_instr[31]}}, in_instr[31:20]};
    assign imm_s   = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b   = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign imm_j   = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
    assign imm_u   = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
    assign shamt   = IS64 ? {58'b0, in_instr[25:20]} : {59'b0, in_instr[24:20]};
    assign shamt_w = {59'b0, in_instr[24:20]};

    assign f7_ok = (f7 == 7'b0000000)
                || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                || (f7 == 7'b0000001 && ENABLE_M);

    always_comb begin
        d_class  = CL_ILLEGAL;
        d_imm    = '0;
        d_word   = 1'b0;
        d_muldiv = 1'b0;
        d_rs1    = 1'b0;
        d_rs2    = 1'b0;
        d_wr     = 1'b0;
        bad      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_class = CL_LUI;
                d_imm   = imm_u;
                d_wr    = 1'b1;
            end
            OPC_AUIPC: begin
                d_class = CL_AUIPC;
                d_imm   = imm_u;
                d_wr    = 1'b1;
            end
            OPC_JAL: begin
                d_class = CL_JAL;
                d_imm   = imm_j;
                d_wr    = 1'b1;
            end
            OPC_JALR: begin
                d_class = CL_JALR;
                d_imm   = imm_i;
                d_rs1   = 1'b1;
                d_wr    = 1'b1;
                bad     = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_class = CL_BRANCH;
                d_imm   = imm_b;
                d_rs1   = 1'b1;
                d_rs2   = 1'b1;
                bad     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                d_class = CL_LOAD;
                d_imm   = imm_i;
                d_rs1   = 1'b1;
                d_wr    = 1'b1;
                bad     = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OPC_STORE: begin
                d_class = CL_STORE;
                d_imm   = imm_s;
                d_rs1   = 1'b1;
                d_rs2   = 1'b1;
                bad     = f3[2] || (!IS64 && f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                d_class = CL_OP_IMM;
                d_rs1   = 1'b1;
                d_wr    = 1'b1;
                d_imm   = imm_i;
                // funct7[0] doubles as shamt[5] on RV64 and must be zero on RV32.
                if (f3 == 3'b001) begin
                    d_imm = shamt;
                    bad   = (f7[6:1] != 6'b000000) || (!IS64 && in_instr[25]);
                end else if (f3 == 3'b101) begin
                    d_imm = shamt;
                    bad   = (f7[6:1] != 6'b000000 && f7[6:1] != 6'b010000)
                         || (!IS64 && in_instr[25]);
                end
            end
            OPC_OP_IMM_32: begin
                d_class = CL_OP_IMM_32;
                d_word  = 1'b1;
                d_rs1   = 1'b1;
                d_wr    = 1'b1;
                d_imm   = imm_i;
                bad     = !IS64;
                if (f3 == 3'b001) begin
                    d_imm = shamt_w;
                    bad   = !IS64 || (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    d_imm = shamt_w;
                    bad   = !IS64 || (f7 != 7'b0000000 && f7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                d_class  = CL_OP;
                d_rs1    = 1'b1;
                d_rs2    = 1'b1;
                d_wr     = 1'b1;
                d_muldiv = (f7 == 7'b0000001);
                bad      = !f7_ok;
            end
            OPC_OP_32: begin
                d_class  = CL_OP_32;
                d_word   = 1'b1;
                d_rs1    = 1'b1;
                d_rs2    = 1'b1;
                d_wr     = 1'b1;
                d_muldiv = (f7 == 7'b0000001);
                bad      = !IS64 || !f7_ok
                        || (f7 == 7'b0000001 && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
            end
            OPC_FENCE: begin
                d_class = CL_FENCE;
            end
            OPC_SYSTEM: begin
                d_class = CL_SYSTEM;
                bad     = (in_instr != 32'h0000_0073) && (in_instr != 32'h0010_0073);
            end
            default: bad = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            d_class  = CL_ILLEGAL;
            d_imm    = '0;
            d_word   = 1'b0;
            d_muldiv = 1'b0;
            d_rs1    = 1'b0;
            d_rs2    = 1'b0;
            d_wr     = 1'b0;
        end
    end

    // flush outranks both handshakes: nothing enters and the held entry is dropped uncounted.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_instr     <= '0;
            imm           <= '0;
            op_class      <= CL_ILLEGAL;
            is_word       <= 1'b0;
            is_muldiv     <= 1'b0;
            uses_rs1      <= 1'b0;
            uses_rs2      <= 1'b0;
            writes_rd     <= 1'b0;
            decoded_count <= '0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_xfer) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_instr <= in_instr;
                imm       <= d_imm[XLEN-1:0];
                op_class  <= d_class;
                is_word   <= d_word;
                is_muldiv <= d_muldiv;
                uses_rs1  <= d_rs1;
                uses_rs2  <= d_rs2;
                writes_rd <= d_wr && (in_instr[11:7] != 5'd0);
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
            if (out_xfer) begin
                decoded_count <= decoded_count + CNT_ONE;
                if (op_class == CL_ILLEGAL) begin
                    illegal_count <= illegal_count + CNT_ONE;
                end
            end
        end
    end

    assign rd      = out_instr[11:7];
    assign rs1     = out_instr[19:15];
    assign rs2     = out_instr[24:20];
    assign funct3  = out_instr[14:12];
    assign funct7  = out_instr[31:25];
    assign illegal = (op_class == CL_ILLEGAL);

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: an RV64 and an RV32 instance share
// the same input stream so width-dependent decode can be compared side by side.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;

    logic        a_in_ready, a_out_valid, a_is_word, a_is_muldiv;
    logic        a_uses_rs1, a_uses_rs2, a_writes_rd, a_illegal;
    logic [63:0] a_out_pc, a_imm;
    logic [31:0] a_out_instr, a_dec_cnt, a_ill_cnt;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3;
    logic [6:0]  a_funct7;
    logic [3:0]  a_op_class;

    logic        b_in_ready, b_out_valid, b_is_word, b_is_muldiv;
    logic        b_uses_rs1, b_uses_rs2, b_writes_rd, b_illegal;
    logic [31:0] b_out_pc, b_imm;
    logic [31:0] b_out_instr, b_dec_cnt, b_ill_cnt;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic [6:0]  b_funct7;
    logic [3:0]  b_op_class;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_dec      = 0;
    int exp_ill64    = 0;
    int exp_ill32    = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .CNT_W(32)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .out_instr(a_out_instr), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2),
        .funct3(a_funct3), .funct7(a_funct7), .imm(a_imm), .op_class(a_op_class),
        .is_word(a_is_word), .is_muldiv(a_is_muldiv), .uses_rs1(a_uses_rs1),
        .uses_rs2(a_uses_rs2), .writes_rd(a_writes_rd), .illegal(a_illegal),
        .decoded_count(a_dec_cnt), .illegal_count(a_ill_cnt)
    );

    rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc[31:0]), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_instr(b_out_instr), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2),
        .funct3(b_funct3), .funct7(b_funct7), .imm(b_imm), .op_class(b_op_class),
        .is_word(b_is_word), .is_muldiv(b_is_muldiv), .uses_rs1(b_uses_rs1),
        .uses_rs2(b_uses_rs2), .writes_rd(b_writes_rd), .illegal(b_illegal),
        .decoded_count(b_dec_cnt), .illegal_count(b_ill_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  cls64;
        logic [3:0]  cls32;
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [14:0] regs;   // {rd, rs1, rs2}
        logic [4:0]  flags;  // {uses_rs1, uses_rs2, writes_rd, is_word, is_muldiv}
    } vec_t;

    vec_t vecs[14];

    task automatic issue(input logic [31:0] instr, input logic [63:0] pc);
        in_instr = instr;
        in_pc    = pc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        tick(); tick();
        reset = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b/%b want 0/0", a_out_valid, b_out_valid);
        end
        tests_run++;
        if (a_dec_cnt !== 32'd0 || a_ill_cnt !== 32'd0 || b_dec_cnt !== 32'd0 || b_ill_cnt !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_counts: got %0d %0d %0d %0d want 0", a_dec_cnt, a_ill_cnt, b_dec_cnt, b_ill_cnt);
        end
        tests_run++;
        if (a_op_class !== 4'd15 || a_illegal !== 1'b1 || a_imm !== 64'd0 || a_rd !== 5'd0
            || a_writes_rd !== 1'b0 || b_op_class !== 4'd15) begin
            tests_failed++;
            $display("[TB] FAIL reset_fields: got cls=%0d ill=%b imm=%h rd=%0d wr=%b want cls=15 ill=1 imm=0 rd=0 wr=0",
                     a_op_class, a_illegal, a_imm, a_rd, a_writes_rd);
        end
    endtask

    task automatic test_vectors();
        logic [4:0]  f64, f32;
        logic [63:0] pc;
        vecs[0]  = '{32'h00500093, 4'd7,  4'd7,  64'd5,                 32'd5,          {5'd1, 5'd0, 5'd5},    5'b10100};
        vecs[1]  = '{32'h800002B7, 4'd0,  4'd0,  64'hFFFFFFFF80000000, 32'h80000000,   {5'd5, 5'd0, 5'd0},    5'b00100};
        vecs[2]  = '{32'hFE000CE3, 4'd4,  4'd4,  64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8,   {5'd25, 5'd0, 5'd0},   5'b11000};
        vecs[3]  = '{32'h00B5053B, 4'd10, 4'd15, 64'd0,                 32'd0,          {5'd10, 5'd10, 5'd11}, 5'b11110};
        vecs[4]  = '{32'h42155513, 4'd7,  4'd15, 64'd33,                32'd0,          {5'd10, 5'd10, 5'd1},  5'b10100};
        vecs[5]  = '{32'h0085B503, 4'd5,  4'd15, 64'd8,                 32'd0,          {5'd10, 5'd11, 5'd8},  5'b10100};
        vecs[6]  = '{32'h02B50533, 4'd8,  4'd8,  64'd0,                 32'd0,          {5'd10, 5'd10, 5'd11}, 5'b11101};
        vecs[7]  = '{32'h00000073, 4'd12, 4'd12, 64'd0,                 32'd0,          {5'd0, 5'd0, 5'd0},    5'b00000};
        vecs[8]  = '{32'h30001073, 4'd15, 4'd15, 64'd0,                 32'd0,          {5'd0, 5'd0, 5'd0},    5'b00000};
        vecs[9]  = '{32'h00000000, 4'd15, 4'd15, 64'd0,                 32'd0,          {5'd0, 5'd0, 5'd0},    5'b00000};
        vecs[10] = '{32'h00002063, 4'd15, 4'd15, 64'd0,                 32'd0,          {5'd0, 5'd0, 5'd0},    5'b00000};
        vecs[11] = '{32'hFFDFF0EF, 4'd2,  4'd2,  64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC,   {5'd1, 5'd31, 5'd29},  5'b00100};
        vecs[12] = '{32'hFEB52E23, 4'd6,  4'd6,  64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC,   {5'd28, 5'd10, 5'd11}, 5'b11000};
        vecs[13] = '{32'h00000013, 4'd7,  4'd7,  64'd0,                 32'd0,          {5'd0, 5'd0, 5'd0},    5'b10000};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            pc = 64'hFFFF_0000_0000_1000 + 64'(i * 4);
            issue(vecs[i].instr, pc);
            f64 = (vecs[i].cls64 == 4'd15) ? 5'b00000 : vecs[i].flags;
            f32 = (vecs[i].cls32 == 4'd15) ? 5'b00000 : vecs[i].flags;
            tests_run++;
            if (a_out_valid !== 1'b1 || a_op_class !== vecs[i].cls64 || a_illegal !== (vecs[i].cls64 == 4'd15)) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d_class64: got v=%b cls=%0d ill=%b want v=1 cls=%0d",
                         i, a_out_valid, a_op_class, a_illegal, vecs[i].cls64);
            end
            tests_run++;
            if (b_out_valid !== 1'b1 || b_op_class !== vecs[i].cls32 || b_illegal !== (vecs[i].cls32 == 4'd15)) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d_class32: got v=%b cls=%0d ill=%b want v=1 cls=%0d",
                         i, b_out_valid, b_op_class, b_illegal, vecs[i].cls32);
            end
            tests_run++;
            if ({a_uses_rs1, a_uses_rs2, a_writes_rd, a_is_word, a_is_muldiv} !== f64
                || {b_uses_rs1, b_uses_rs2, b_writes_rd, b_is_word, b_is_muldiv} !== f32) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d_flags: got %b/%b want %b/%b", i,
                         {a_uses_rs1, a_uses_rs2, a_writes_rd, a_is_word, a_is_muldiv},
                         {b_uses_rs1, b_uses_rs2, b_writes_rd, b_is_word, b_is_muldiv}, f64, f32);
            end
            if (vecs[i].cls64 != 4'd15) begin
                tests_run++;
                if (a_imm !== vecs[i].imm64) begin
                    tests_failed++;
                    $display("[TB] FAIL vec%0d_imm64: got %h want %h", i, a_imm, vecs[i].imm64);
                end
            end
            if (vecs[i].cls32 != 4'd15) begin
                tests_run++;
                if (b_imm !== vecs[i].imm32) begin
                    tests_failed++;
                    $display("[TB] FAIL vec%0d_imm32: got %h want %h", i, b_imm, vecs[i].imm32);
                end
            end
            tests_run++;
            if ({a_rd, a_rs1, a_rs2} !== vecs[i].regs || a_out_instr !== vecs[i].instr
                || a_out_pc !== pc || b_out_pc !== pc[31:0] || a_funct3 !== vecs[i].instr[14:12]) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d_fields: got rd/rs1/rs2=%0d/%0d/%0d instr=%h pc=%h/%h want %0d/%0d/%0d %h %h",
                         i, a_rd, a_rs1, a_rs2, a_out_instr, a_out_pc, b_out_pc,
                         vecs[i].regs[14:10], vecs[i].regs[9:5], vecs[i].regs[4:0], vecs[i].instr, pc);
            end
            tick();
            exp_dec++;
            if (vecs[i].cls64 == 4'd15) exp_ill64++;
            if (vecs[i].cls32 == 4'd15) exp_ill32++;
            tests_run++;
            if (a_out_valid !== 1'b0 || a_dec_cnt !== 32'(exp_dec) || b_dec_cnt !== 32'(exp_dec)
                || a_ill_cnt !== 32'(exp_ill64) || b_ill_cnt !== 32'(exp_ill32)) begin
                tests_failed++;
                $display("[TB] FAIL vec%0d_counts: got v=%b dec=%0d/%0d ill=%0d/%0d want v=0 dec=%0d ill=%0d/%0d",
                         i, a_out_valid, a_dec_cnt, b_dec_cnt, a_ill_cnt, b_ill_cnt, exp_dec, exp_ill64, exp_ill32);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream [4];
        stream[0] = 32'h00500093;
        stream[1] = 32'h800002B7;
        stream[2] = 32'hFE000CE3;
        stream[3] = 32'h02B50533;
        out_ready = 1'b0;
        issue(stream[0], 64'h2000);
        in_valid = 1'b1;
        in_instr = stream[1];
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall%0d_in_ready: got %b/%b want 0/0", k, a_in_ready, b_in_ready);
            end
            tick();
            tests_run++;
            if (a_out_valid !== 1'b1 || a_out_instr !== stream[0] || a_imm !== 64'd5
                || a_out_pc !== 64'h2000 || a_dec_cnt !== 32'(exp_dec)) begin
                tests_failed++;
                $display("[TB] FAIL stall%0d_hold: got v=%b instr=%h imm=%h pc=%h dec=%0d want v=1 instr=%h imm=5 pc=2000 dec=%0d",
                         k, a_out_valid, a_out_instr, a_imm, a_out_pc, a_dec_cnt, stream[0], exp_dec);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (a_in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_in_ready: got %b want 1", a_in_ready);
        end
        for (int k = 1; k < 4; k++) begin
            in_instr = stream[k];
            tick();
            exp_dec++;
            tests_run++;
            if (a_out_valid !== 1'b1 || a_out_instr !== stream[k] || a_dec_cnt !== 32'(exp_dec)) begin
                tests_failed++;
                $display("[TB] FAIL b2b%0d: got v=%b instr=%h dec=%0d want v=1 instr=%h dec=%0d",
                         k, a_out_valid, a_out_instr, a_dec_cnt, stream[k], exp_dec);
            end
        end
        in_valid = 1'b0;
        tick();
        exp_dec++;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_dec_cnt !== 32'(exp_dec) || a_ill_cnt !== 32'(exp_ill64)) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain: got v=%b dec=%0d ill=%0d want v=0 dec=%0d ill=%0d",
                     a_out_valid, a_dec_cnt, a_ill_cnt, exp_dec, exp_ill64);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(32'h00000000, 64'h3000);
        in_valid  = 1'b1;
        in_instr  = 32'h00500093;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        tests_run++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_in_ready: got rdy=%b/%b v=%b want 0/0 v=1", a_in_ready, b_in_ready, a_out_valid);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_valid: got %b/%b want 0/0", a_out_valid, b_out_valid);
        end
        tests_run++;
        if (a_dec_cnt !== 32'(exp_dec) || a_ill_cnt !== 32'(exp_ill64) || b_ill_cnt !== 32'(exp_ill32)) begin
            tests_failed++;
            $display("[TB] FAIL flush_counts: got dec=%0d ill=%0d/%0d want dec=%0d ill=%0d/%0d",
                     a_dec_cnt, a_ill_cnt, b_ill_cnt, exp_dec, exp_ill64, exp_ill32);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        issue(32'h00500093, 64'h4000);
        in_valid = 1'b1;
        in_instr = 32'h800002B7;
        reset    = 1'b1;
        flush    = 1'b1;
        tick();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_dec = 0; exp_ill64 = 0; exp_ill32 = 0;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_dec_cnt !== 32'd0 || a_ill_cnt !== 32'd0 || b_dec_cnt !== 32'd0
            || a_op_class !== 4'd15 || a_illegal !== 1'b1 || a_out_instr !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset: got v=%b dec=%0d ill=%0d cls=%0d instr=%h want v=0 dec=0 ill=0 cls=15 instr=0",
                     a_out_valid, a_dec_cnt, a_ill_cnt, a_op_class, a_out_instr);
        end
        out_ready = 1'b1;
        issue(32'h00500093, 64'h5000);
        tick();
        exp_dec++;
        tests_run++;
        if (a_dec_cnt !== 32'(exp_dec) || a_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_count: got dec=%0d v=%b want dec=%0d v=0", a_dec_cnt, a_out_valid, exp_dec);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
